pe_acc_sat: RTL and testbench

PE_ACC_SAT -- requirements
Module: pe_acc_sat

---
 rtl/pe_acc_sat_if.sv | 28 ++
 rtl/pe_acc_sat.sv | 124 ++++++++++++
 tb/tb_pe_acc_sat.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pe_acc_sat_if.sv
// Operand/result bus of one systolic PE: neighbour operands and preload come in,
// forwarded operands, the saturated result and the status flags go out.
interface pe_acc_sat_if #(
  parameter int D_W = 8
);
  logic                  I_VLD;
  logic                  I_LAST;
  logic signed [D_W-1:0] I_X;
  logic signed [D_W-1:0] I_W;
  logic signed [D_W-1:0] I_D;
  logic                  O_VLD;
  logic signed [D_W-1:0] O_X;
  logic signed [D_W-1:0] O_W;
  logic signed [D_W-1:0] O_D;
  logic                  O_DONE;
  logic                  O_OVF;
  logic                  O_BUSY;

  modport master (
    output I_VLD, I_LAST, I_X, I_W, I_D,
    input  O_VLD, O_X, O_W, O_D, O_DONE, O_OVF, O_BUSY
  );

  modport slave (
    input  I_VLD, I_LAST, I_X, I_W, I_D,
    output O_VLD, O_X, O_W, O_D, O_DONE, O_OVF, O_BUSY
  );
endinterface

// File: rtl/pe_acc_sat.sv
// Systolic processing element: forwards X/W to neighbours, multiplies them,
// rounds the product back to FRAC fraction bits and accumulates with saturation.
// Two-edge latency from an accepted pair to O_D; a small FSM marks the final pair.
module pe_acc_sat #(
  parameter int D_W  = 8,
  parameter int FRAC = 5,
  parameter int G    = 4
) (
  input  logic         I_CLK,
  input  logic         I_ASYN_RSTN,
  input  logic         I_SYNC_RSTN,
  pe_acc_sat_if.slave  bus
);
  localparam int P_W   = 2 * D_W;
  localparam int ACC_W = 2 * D_W - FRAC + G;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [D_W-1:0]   D_MAX   = {1'b0, {(D_W-1){1'b1}}};
  localparam logic signed [D_W-1:0]   D_MIN   = {1'b1, {(D_W-1){1'b0}}};
  localparam logic signed [P_W:0]     RND_K   = (P_W+1)'(2 ** (FRAC - 1));

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_FLUSH, ST_DONE} state_t;

  state_t                  state, state_nxt;
  logic                    accept;
  logic                    o_vld;
  logic signed [D_W-1:0]   o_x, o_w, o_d;
  logic                    o_ovf;
  logic signed [P_W-1:0]   prod;
  logic                    p_vld;
  logic signed [ACC_W-1:0] acc;

  logic signed [P_W:0]     p_rnd;
  logic signed [P_W:0]     r_full;
  logic signed [ACC_W-1:0] r_ext;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [D_W-1:0]   d_nxt;
  logic                    ovf_acc, ovf_d;
  logic [ACC_W-D_W:0]      hi_bits;

  // operands are dropped while the last product drains through stage 2
  assign accept = bus.I_VLD && (state != ST_FLUSH);

  // round half up, rescale, accumulate and clamp twice (accumulator, then output)
  always_comb begin
    p_rnd   = (P_W+1)'(prod) + RND_K;
    r_full  = p_rnd >>> FRAC;
    r_ext   = ACC_W'(r_full);
    sum     = (ACC_W+1)'(acc) + (ACC_W+1)'(r_ext);
    ovf_acc = sum[ACC_W] != sum[ACC_W-1];
    acc_nxt = ovf_acc ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    hi_bits = acc_nxt[ACC_W-1:D_W-1];
    ovf_d   = !((&hi_bits) || !(|hi_bits));
    d_nxt   = ovf_d ? (acc_nxt[ACC_W-1] ? D_MIN : D_MAX) : acc_nxt[D_W-1:0];
  end

  // forwarding, stage-1 product and stage-2 accumulator registers
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      o_x   <= '0;
      o_w   <= '0;
      o_vld <= 1'b0;
      prod  <= '0;
      p_vld <= 1'b0;
      acc   <= '0;
      o_d   <= '0;
      o_ovf <= 1'b0;
    end else if (!I_SYNC_RSTN) begin
      o_x   <= '0;
      o_w   <= '0;
      o_vld <= 1'b0;
      p_vld <= 1'b0;
      acc   <= ACC_W'(bus.I_D);
      o_d   <= bus.I_D;
      o_ovf <= 1'b0;
    end else begin
      o_vld <= accept;
      p_vld <= accept;
      if (accept) begin
        o_x  <= bus.I_X;
        o_w  <= bus.I_W;
        prod <= P_W'(bus.I_X) * P_W'(bus.I_W);
      end
      if (p_vld) begin
        acc <= acc_nxt;
        o_d <= d_nxt;
        if (ovf_acc || ovf_d) o_ovf <= 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  // next state: the last pair goes through FLUSH so DONE lines up with its result
  always_comb begin
    state_nxt = state;
    if (!I_SYNC_RSTN) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state_nxt = bus.I_LAST ? ST_FLUSH : ST_ACC;
        ST_ACC:   if (accept && bus.I_LAST) state_nxt = ST_FLUSH;
        ST_FLUSH: state_nxt = ST_DONE;
        ST_DONE:  if (accept) state_nxt = bus.I_LAST ? ST_FLUSH : ST_ACC;
                  else        state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.O_VLD  = o_vld;
  assign bus.O_X    = o_x;
  assign bus.O_W    = o_w;
  assign bus.O_D    = o_d;
  assign bus.O_OVF  = o_ovf;
  assign bus.O_BUSY = (state == ST_FLUSH);
  assign bus.O_DONE = (state == ST_DONE);
endmodule

// File: tb/tb_pe_acc_sat.sv
// Bench for pe_acc_sat (D_W=8, FRAC=5, G=4): directed pairs push the hand-computed
// O_D/O_OVF into a queue; a negedge monitor pops one entry for every result edge.
module tb_pe_acc_sat;
  logic I_CLK = 1'b0;
  logic I_ASYN_RSTN = 1'b0;
  logic I_SYNC_RSTN = 1'b1;

  pe_acc_sat_if #(.D_W(8)) bus ();

  pe_acc_sat #(.D_W(8), .FRAC(5), .G(4)) dut (
    .I_CLK       (I_CLK),
    .I_ASYN_RSTN (I_ASYN_RSTN),
    .I_SYNC_RSTN (I_SYNC_RSTN),
    .bus         (bus)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic [7:0] d;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   pend  = 1'b0;

  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] d);
    bus.I_VLD   = 1'b0;
    bus.I_LAST  = 1'b0;
    bus.I_D     = d;
    I_SYNC_RSTN = 1'b0;
    tick();
    I_SYNC_RSTN = 1'b1;
    chk("preload_od", $unsigned(bus.O_D), {24'b0, d});
  endtask

  task automatic pair(input logic [7:0] x, input logic [7:0] w, input logic last,
                      input logic push, input logic [7:0] ed, input logic eo);
    exp_t e;
    bus.I_VLD  = 1'b1;
    bus.I_LAST = last;
    bus.I_X    = x;
    bus.I_W    = w;
    if (push) begin
      e.d   = ed;
      e.ovf = eo;
      sb.push_back(e);
    end
    tick();
    bus.I_VLD  = 1'b0;
    bus.I_LAST = 1'b0;
  endtask

  // a result lands on O_D one edge after O_VLD, unless a reset wipes the product
  always @(negedge I_CLK) begin
    exp_t e;
    if (pend) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: O_D=0x%0h with nothing expected", bus.O_D);
      end else begin
        e = sb.pop_front();
        if (bus.O_D !== e.d || bus.O_OVF !== e.ovf) begin
          n_err++;
          $display("FAIL sb_result: O_D=0x%0h O_OVF=%0b want O_D=0x%0h O_OVF=%0b",
                   bus.O_D, bus.O_OVF, e.d, e.ovf);
        end
      end
    end
    pend = bus.O_VLD && I_SYNC_RSTN && I_ASYN_RSTN;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.I_VLD  = 1'b0;
    bus.I_LAST = 1'b0;
    bus.I_X    = '0;
    bus.I_W    = '0;
    bus.I_D    = '0;

    // asynchronous reset state, before any clock edge
    #2;
    chk("rst_od",   $unsigned(bus.O_D), 0);
    chk("rst_ox",   $unsigned(bus.O_X), 0);
    chk("rst_vld",  bus.O_VLD, 0);
    chk("rst_ovf",  bus.O_OVF, 0);
    chk("rst_done", bus.O_DONE, 0);
    chk("rst_busy", bus.O_BUSY, 0);
    tick();
    tick();
    I_ASYN_RSTN = 1'b1;
    tick();

    // basic dot product: 1.0*1.0 + 0.5*0.5 = 1.25
    preload(8'h00);
    pair(8'h20, 8'h20, 1'b0, 1'b1, 8'h20, 1'b0);
    chk("fwd_vld", bus.O_VLD, 1);
    chk("fwd_x",   $unsigned(bus.O_X), 32'h20);
    pair(8'h10, 8'h10, 1'b1, 1'b1, 8'h28, 1'b0);
    chk("fwd_x2",    $unsigned(bus.O_X), 32'h10);
    chk("fwd_w2",    $unsigned(bus.O_W), 32'h10);
    chk("flush_bsy", bus.O_BUSY, 1);
    chk("flush_dn",  bus.O_DONE, 0);
    tick();
    chk("done_hi",   bus.O_DONE, 1);
    chk("done_od",   $unsigned(bus.O_D), 32'h28);
    chk("idle_vld",  bus.O_VLD, 0);
    tick();
    chk("done_lo",   bus.O_DONE, 0);
    chk("ovf_clr",   bus.O_OVF, 0);

    // rounding: +half rounds up, -half rounds up to 0, most negative product
    preload(8'h00);
    pair(8'h01, 8'h10, 1'b1, 1'b1, 8'h01, 1'b0);
    tick();
    tick();
    preload(8'h00);
    pair(8'h01, 8'hF0, 1'b1, 1'b1, 8'h00, 1'b0);
    tick();
    tick();
    preload(8'h00);
    pair(8'h80, 8'h20, 1'b1, 1'b1, 8'h80, 1'b0);
    tick();
    tick();

    // positive output clamp: 127*127 -> ACC 504, O_D pinned at 0x7F, sticky flag
    preload(8'h00);
    pair(8'h7F, 8'h7F, 1'b1, 1'b1, 8'h7F, 1'b1);
    tick();
    chk("sat_acc", $unsigned(dut.acc), 504);
    tick();
    tick();
    chk("ovf_sticky", bus.O_OVF, 1);

    // negative output clamp: -4.0 + (-1.0) -> ACC -160, O_D pinned at 0x80
    preload(8'h80);
    chk("ovf_synclr", bus.O_OVF, 0);
    pair(8'hE0, 8'h20, 1'b1, 1'b1, 8'h80, 1'b1);
    tick();
    tick();

    // operands offered during FLUSH are ignored
    preload(8'h00);
    pair(8'h20, 8'h20, 1'b1, 1'b1, 8'h20, 1'b0);
    chk("fl_busy", bus.O_BUSY, 1);
    bus.I_VLD = 1'b1;
    bus.I_X   = 8'h55;
    bus.I_W   = 8'h33;
    tick();
    bus.I_VLD = 1'b0;
    chk("fl_vld",  bus.O_VLD, 0);
    chk("fl_x",    $unsigned(bus.O_X), 32'h20);
    chk("fl_w",    $unsigned(bus.O_W), 32'h20);
    chk("fl_done", bus.O_DONE, 1);
    tick();
    chk("fl_od",   $unsigned(bus.O_D), 32'h20);

    // synchronous preload one cycle after a pair drops the in-flight product
    preload(8'h00);
    pair(8'h20, 8'h20, 1'b0, 1'b0, 8'h00, 1'b0);
    I_SYNC_RSTN = 1'b0;
    bus.I_D     = 8'h10;
    tick();
    I_SYNC_RSTN = 1'b1;
    chk("sr_od",   $unsigned(bus.O_D), 32'h10);
    chk("sr_acc",  $unsigned(dut.acc), 16);
    chk("sr_vld",  bus.O_VLD, 0);
    chk("sr_busy", bus.O_BUSY, 0);
    tick();
    chk("sr_drop", $unsigned(bus.O_D), 32'h10);

    // asynchronous pulse between edges clears outputs immediately
    pair(8'h20, 8'h20, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("ar_pre_x", $unsigned(bus.O_X), 32'h20);
    #1;
    I_ASYN_RSTN = 1'b0;
    #1;
    chk("ar_od",  $unsigned(bus.O_D), 0);
    chk("ar_ox",  $unsigned(bus.O_X), 0);
    chk("ar_vld", bus.O_VLD, 0);
    chk("ar_acc", $unsigned(dut.acc), 0);
    I_ASYN_RSTN = 1'b1;
    tick();
    tick();
    chk("ar_od_hold", $unsigned(bus.O_D), 0);
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
